// File: rtl/grizzly_ctrl_pkg.sv
// Shared types and constants for the run/single-step controller.
package grizzly_ctrl_pkg;

  // Controller states; Advance is high in every state except IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    RUN  = 2'd2
  } state_e;

  // One instruction cycle is PHASES Cin cycles; PHASE_LAST is the boundary phase.
  localparam int         PHASES     = 3;
  localparam logic [1:0] PHASE_LAST = 2'(PHASES - 1);

endpackage

// File: rtl/btn_debounce.sv
// Raw button conditioner: 2-FF synchronizer, stability counter and a
// one-cycle pulse on each accepted press (debounced 0->1). Releases are
// accepted silently.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic Cin,
  input  logic Reset,
  input  logic Btn_In,
  output logic Level,
  output logic Press
);

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] stable_cnt;
  logic          level_d;

  // Synchronize, count consecutive mismatching samples, and register the press edge.
  // NOTE: every flop here is reset, including the synchronizer pair, so the
  // debounced level starts known-low and no spurious press fires after reset.
  always_ff @(posedge Cin or posedge Reset) begin
    if (Reset) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      stable_cnt <= '0;
      Level      <= 1'b0;
      level_d    <= 1'b0;
      Press      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make sync_2 take the old sync_1, which
      // is what forms the two-stage synchronizer; blocking would collapse it.
      sync_1  <= Btn_In;
      sync_2  <= sync_1;
      level_d <= Level;
      Press   <= Level & ~level_d;
      if (sync_2 == Level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        Level      <= sync_2;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/run_step_ctrl.sv
// Run/single-step controller driving the Advance input of the three-phase
// clock generator. Advance is only ever dropped at an instruction boundary
// (after the last phase) or by Reset, so the phase generator always sees
// whole 3-cycle instruction cycles.
module run_step_ctrl
  import grizzly_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic             Cin,
  input  logic             Reset,
  input  logic             Run_Btn,
  input  logic             Step_Btn,
  input  logic             Halt_Req,
  output logic             Advance,
  output logic             Running,
  output logic [1:0]       Phase_Idx,
  output logic [CNT_W-1:0] Cycle_Count
);

  logic   run_press;
  logic   step_press;
  logic   run_level_unused;
  logic   step_level_unused;

  state_e     state;
  state_e     state_n;
  logic [1:0] phase_n;
  logic       stop_pending;
  logic       stop_n;
  logic       count_inc;
  logic       stop_req;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_btn (
    .Cin    (Cin),
    .Reset  (Reset),
    .Btn_In (Run_Btn),
    .Level  (run_level_unused),
    .Press  (run_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
    .Cin    (Cin),
    .Reset  (Reset),
    .Btn_In (Step_Btn),
    .Level  (step_level_unused),
    .Press  (step_press)
  );

  // A stop can be requested by the run button or the datapath in any RUN cycle.
  assign stop_req = run_press | Halt_Req;

  // Next-state, next-phase and stop/count decisions.
  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_n   = state;
    phase_n   = Phase_Idx;
    stop_n    = stop_pending;
    count_inc = 1'b0;
    unique case (state)
      IDLE: begin
        // Halt_Req is deliberately ignored here so stepping past a HLT works;
        // run wins over a simultaneous step, which is dropped.
        phase_n = 2'd0;
        if (run_press) begin
          state_n = RUN;
        end else if (step_press) begin
          state_n = STEP;
        end
      end
      STEP: begin
        // Presses during a step are dropped, not queued.
        if (Phase_Idx == PHASE_LAST) begin
          count_inc = 1'b1;
          state_n   = IDLE;
          phase_n   = 2'd0;
        end else begin
          phase_n = Phase_Idx + 1'b1;
        end
      end
      RUN: begin
        if (Phase_Idx == PHASE_LAST) begin
          count_inc = 1'b1;
          phase_n   = 2'd0;
          // A request arriving on the boundary cycle itself still stops here.
          if (stop_pending || stop_req) begin
            state_n = IDLE;
            stop_n  = 1'b0;
          end
        end else begin
          phase_n = Phase_Idx + 1'b1;
          stop_n  = stop_pending | stop_req;
        end
      end
      default: begin
        state_n = IDLE;
        phase_n = 2'd0;
        stop_n  = 1'b0;
      end
    endcase
  end

  // State, phase and counter registers; outputs are registered from next-state.
  always_ff @(posedge Cin or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      Phase_Idx    <= 2'd0;
      stop_pending <= 1'b0;
      Cycle_Count  <= '0;
      Advance      <= 1'b0;
      Running      <= 1'b0;
    end else begin
      state        <= state_n;
      Phase_Idx    <= phase_n;
      stop_pending <= stop_n;
      Advance      <= (state_n != IDLE);
      Running      <= (state_n == RUN);
      if (count_inc) begin
        Cycle_Count <= Cycle_Count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_run_step_ctrl.sv
// Directed self-checking bench for run_step_ctrl with DEBOUNCE_CYCLES=4.
// Expected per-edge outputs are derived from the press latency rule
// (pulse DEBOUNCE_CYCLES+2 edges after the first stable raw 1, Advance one
// edge later); a scoreboard additionally checks every Advance-high interval.
module tb_run_step_ctrl;

  localparam int DEB   = 4;
  localparam int CNT_W = 16;

  typedef struct {
    int len;
    int count;
  } sb_item_t;

  logic             Cin;
  logic             Reset;
  logic             Run_Btn;
  logic             Step_Btn;
  logic             Halt_Req;
  logic             Advance;
  logic             Running;
  logic [1:0]       Phase_Idx;
  logic [CNT_W-1:0] Cycle_Count;

  int       vectors     = 0;
  int       miscompares = 0;
  int       exp_count   = 0;
  int       hi_len      = 0;
  sb_item_t sb_q[$];

  run_step_ctrl #(.DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W)) dut (
    .Cin         (Cin),
    .Reset       (Reset),
    .Run_Btn     (Run_Btn),
    .Step_Btn    (Step_Btn),
    .Halt_Req    (Halt_Req),
    .Advance     (Advance),
    .Running     (Running),
    .Phase_Idx   (Phase_Idx),
    .Cycle_Count (Cycle_Count)
  );

  initial Cin = 1'b0;
  always #5 Cin = ~Cin;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge Cin);
    #1;
  endtask

  function automatic bit in_rng(input int e, input int lo, input int hi);
    return (e >= lo) && (e <= hi);
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_adv"},   {31'd0, Advance},   32'd0);
    check({tag, "_run"},   {31'd0, Running},   32'd0);
    check({tag, "_phase"}, {30'd0, Phase_Idx}, 32'd0);
    check({tag, "_count"}, {16'd0, Cycle_Count}, 32'd0);
  endtask

  task automatic reset_dut();
    Run_Btn  = 1'b0;
    Step_Btn = 1'b0;
    Halt_Req = 1'b0;
    Reset    = 1'b1;
    tick();
    tick();
    Reset     = 1'b0;
    exp_count = 0;
  endtask

  // Drive edge-indexed button/halt patterns for n_edges edges and check all
  // outputs after each edge. Advance is expected high on edges
  // [start_e, stop_e); a count lands on every third edge from start_e+3.
  task automatic run_seq(input string tag, input int n_edges,
                         input int run_lo, input int run_hi,
                         input int run2_lo, input int run2_hi,
                         input int step_lo, input int step_hi,
                         input logic [15:0] step_tog, input int halt_e,
                         input int start_e, input int stop_e, input bit is_run);
    sb_item_t it;
    bit       adv;
    int       done;
    int       nx;
    if (start_e < n_edges) begin
      it.len   = stop_e - start_e;
      it.count = exp_count + (stop_e - start_e) / 3;
      sb_q.push_back(it);
    end
    for (int e = -1; e < n_edges; e++) begin
      if (e >= 0) begin
        tick();
        adv  = (e >= start_e) && (e < stop_e);
        done = (e < start_e) ? 0 : (((e < stop_e) ? e : stop_e) - start_e) / 3;
        check($sformatf("%s_adv@%0d", tag, e),   {31'd0, Advance},   {31'd0, adv});
        check($sformatf("%s_run@%0d", tag, e),   {31'd0, Running},   {31'd0, is_run && adv});
        check($sformatf("%s_phase@%0d", tag, e), {30'd0, Phase_Idx}, adv ? 32'((e - start_e) % 3) : 32'd0);
        check($sformatf("%s_count@%0d", tag, e), {16'd0, Cycle_Count}, 32'(exp_count + done));
      end
      nx       = e + 1;
      Run_Btn  = in_rng(nx, run_lo, run_hi) || in_rng(nx, run2_lo, run2_hi);
      Step_Btn = in_rng(nx, step_lo, step_hi) || ((nx < 16) ? step_tog[4'(nx)] : 1'b0);
      Halt_Req = (e == halt_e);
    end
    Run_Btn  = 1'b0;
    Step_Btn = 1'b0;
    Halt_Req = 1'b0;
    if (start_e < n_edges) exp_count += (stop_e - start_e) / 3;
  endtask

  // Scoreboard monitor: measure each Advance-high interval at the falling
  // edge and compare its length and the resulting count with the queue.
  always @(negedge Cin) begin
    sb_item_t exp_it;
    if (Advance === 1'b1) begin
      hi_len++;
    end else if (hi_len != 0) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_interval", 32'(hi_len), 32'd0);
      end else begin
        exp_it = sb_q.pop_front();
        check("sb_len",   32'(hi_len), 32'(exp_it.len));
        check("sb_count", {16'd0, Cycle_Count}, 32'(exp_it.count));
      end
      hi_len = 0;
    end
  end

  initial begin
    Run_Btn  = 1'b0;
    Step_Btn = 1'b0;
    Halt_Req = 1'b0;
    Reset    = 1'b1;

    // 1: reset held, then released; nothing moves for 20 cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle($sformatf("s1_rst%0d", i));
    end
    Reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_idle($sformatf("s1_idle%0d", i));
    end

    // 2: Step held on edges 0..9: press at 6, Advance on 7..9, count 1.
    run_seq("s2", 25, 1, 0, 1, 0, 0, 9, 16'h0000, -1, 7, 10, 1'b0);

    // 3a: Step toggles 1,0,1 then stays low: no step.
    run_seq("s3a", 20, 1, 0, 1, 0, 1, 0, 16'h0005, -1, 1000, 1000, 1'b0);
    // 3b: toggles 1,0,1 then stable high from edge 2: press at 8, Advance 9..11.
    run_seq("s3b", 25, 1, 0, 1, 0, 2, 11, 16'h0005, -1, 9, 12, 1'b0);

    // 4: RUN from edge 7; second press pulse at edge 38 (phase 1) stops at
    // the boundary after edge 39: 33 high cycles, 11 instructions.
    reset_dut();
    run_seq("s4", 55, 0, 7, 32, 39, 1, 0, 16'h0000, -1, 7, 40, 1'b1);

    // 5a: Halt_Req sampled at a phase-0 cycle: stop at that instruction's end.
    reset_dut();
    run_seq("s5a", 30, 0, 7, 1, 0, 1, 0, 16'h0000, 10, 7, 13, 1'b1);
    // 5b: Halt_Req sampled at a phase-2 cycle: stop on that same boundary.
    run_seq("s5b", 30, 0, 7, 1, 0, 1, 0, 16'h0000, 15, 7, 16, 1'b1);

    // 6a: async Reset at phase 1 in RUN drops Advance before the next edge.
    reset_dut();
    begin
      sb_item_t it;
      it.len   = 4;
      it.count = 0;
      sb_q.push_back(it);
    end
    Run_Btn = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (e == 7) Run_Btn = 1'b0;
    end
    check("s6_pre_adv",   {31'd0, Advance},     32'd1);
    check("s6_pre_phase", {30'd0, Phase_Idx},   32'd1);
    check("s6_pre_count", {16'd0, Cycle_Count}, 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    check_idle("s6_async");
    tick();
    tick();
    Reset     = 1'b0;
    exp_count = 0;

    // 6b: Run and Step pressed together from IDLE: RUN wins, step dropped.
    run_seq("s6b", 25, 0, 7, 1, 0, 0, 7, 16'h0000, 9, 7, 10, 1'b1);

    repeat (3) tick();
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
